bus_mem_resp: RTL
=================

Name: bus_mem_resp

Overview:
Bus target memory responder that sits at the far end of the video controller's bus master port. It services write requests (cmd 100), data phases (cmd 001) and burst read requests (cmd 010) against an internal word-addressed frame-buffer RAM. Read data is returned as bid/grant-arbitrated response beats, and every write is acknowledged with a write response. It is the source of RGB pixel words for the video controller's fetch path.

Parameters:
AW, 10, log2 of memory depth in 32-bit words (default 1024 words)
RESP_TAR, 4'h0, value driven on reqtar during every response

Ports:
clk  in  1  system clock, all logic on posedge
reset  in  1  asynchronous, active-low reset
selin  in  1  this target is addressed on the current cycle
cmdin  in  3  000 idle, 001 data phase, 010 read req, 100 write req
lenin  in  2  burst length code: 00=1, 01=2, 10=4, 11=8 beats
addrdatain  in  32  byte address on request cycles, write data on data phases
ackin  in  1  arbiter grant for this block's bid
reqout  out  2  2'b11 = bid for bus, 2'b00 = no bid
lenout  out  2  length code of the response burst in progress
addrdataout  out  32  read data beat, else 0
cmdout  out  3  011 read data, 101 write response, 000 idle
reqtar  out  4  RESP_TAR while responding, else 0

Behaviour:
- Reset (reset=0, async): state IDLE; reqout, lenout, addrdataout, cmdout and reqtar all 0; beat counter and address register 0. RAM contents are not cleared. Reset mid-burst aborts the burst with no further beats.
- Address: word index = addr[AW+1:2]. Bits [1:0] are ignored. Upper bits alias. Index increments by 1 per beat and wraps modulo 2^AW.
- Beat count N = 1 << lenin, captured on the request cycle.
- IDLE:
  - selin && cmdin==100: capture addr and N, go to WR_DATA.
  - selin && cmdin==010: capture addr and N, go to RD_BID.
  - Any other cmd: ignored.
- WR_DATA:
  - Each cycle with cmdin==001 (selin not required): write addrdatain into RAM[idx], increment idx, decrement count.
  - After beat N, go to WR_BID.
  - cmdin==000 stalls with no write.
  - Any other cmd is ignored, as are new requests.
- WR_BID: reqout=2'b11 until ackin=1 is sampled, then go to WR_RESP.
- WR_RESP: exactly one cycle of cmdout=101, reqtar=RESP_TAR, reqout=2'b11, lenout=captured code; then IDLE.
- RD_BID: reqout=2'b11 until ackin, then go to RD_DATA.
  - First data beat appears in the cycle after ackin is sampled.
  - Latency from request to first beat is 2 cycles when ackin is already high.
- RD_DATA: N consecutive cycles of cmdout=011, addrdataout=RAM[idx], lenout=code, reqtar=RESP_TAR, reqout=2'b11, with idx incrementing each beat.
  - Beats are never stalled once granted; ackin deasserting mid-burst is ignored.
  - After the last beat, all outputs drop to 0 on the next cycle and state returns to IDLE.
- Outputs are registered. In non-driving cycles addrdataout=0 and cmdout=000.
- Requests arriving while not in IDLE are dropped; no queueing.
- Read-after-write: a read request accepted after WR_RESP returns the newly written data.

Optional Feature:
BUS_MEM_RESP_RANGECHK_EN
- Defined:
  - On a request whose addr[31:AW+2] is not 0, the block skips data transfer, bids, and returns one beat of cmdout=111 (error), addrdataout = the captured address, lenout=00.
  - An out-of-range write still consumes its N data phases without writing RAM.
  - A burst that wraps is not an error.
- Undefined: upper bits alias silently and cmd 111 is never produced.

Decomposition:
- Shared package bus_pkg holds:
  - bus_cmd_e enum (IDLE=000, DATA=001, RD_REQ=010, RD_DATA=011, WR_REQ=100, WR_RESP=101, ERR=111);
  - bus_len_e codes and a function len_to_beats;
  - the REQ_BID=2'b11 constant.
- The state enum stays local.
- One sub-module: bus_mem_ram, a single-port 2^AW x 32 synchronous RAM with registered read, instantiated once.
  - The FSM issues the read address one cycle ahead to hide the RAM latency.

Test Plan:
- Reset: hold reset=0 with random inputs -> all outputs 0. Release, then hold cmd 000 for 10 cycles -> outputs remain 0.
- Single write and read:
  - Write req addr 0x0000_0010, lenin=00, one data phase 0xDEADBEEF, ackin=1 -> exactly one cycle of cmdout=101, reqtar=0.
  - Read req same addr, lenin=00 -> one beat of 011 with 0xDEADBEEF, 2 cycles after the request.
- Burst of 4 with delayed grant:
  - Write 0x11,0x22,0x33,0x44 at 0x100; read lenin=10 with ackin held 0 for 5 cycles.
  - Expect reqout=11 throughout the wait, then 4 consecutive beats 0x11..0x44 with lenout=10.
- Wrap: AW=10, write 8 beats at 0xFF8 (idx 1022) -> data lands at idx 1022,1023,0..5; an 8-beat read at 0xFF8 returns it in order.
- Abort and ignore:
  - Assert reset=0 during beat 2 of an 8-beat read -> outputs 0 asynchronously; a subsequent read returns intact RAM data.
  - A read request issued during WR_DATA is ignored.
- RANGECHK_EN: read at 0x0001_0000 with AW=10 -> one beat, cmdout=111, addrdataout=0x0001_0000, and RAM is unchanged.

Source files
------------

// File: rtl/bus_pkg.sv
// bus_pkg: command codes, burst length codes and the bid constant used on the
// video controller bus, shared by the bus target responder and its RAM.
package bus_pkg;

   // Bus command encoding carried on cmdin/cmdout.
   typedef enum logic [2:0] {
      IDLE    = 3'b000,
      DATA    = 3'b001,
      RD_REQ  = 3'b010,
      RD_DATA = 3'b011,
      WR_REQ  = 3'b100,
      WR_RESP = 3'b101,
      ERR     = 3'b111
   } bus_cmd_e;

   // Burst length codes carried on lenin/lenout.
   typedef enum logic [1:0] {
      LEN_1 = 2'b00,
      LEN_2 = 2'b01,
      LEN_4 = 2'b10,
      LEN_8 = 2'b11
   } bus_len_e;

   // Value driven on the request lines while bidding for the bus.
   localparam logic [1:0] REQ_BID = 2'b11;

   // Number of beats in a burst for a given length code.
   function automatic logic [3:0] len_to_beats(input bus_len_e len);
      return 4'd1 << len;
   endfunction

endpackage : bus_pkg

// File: rtl/bus_mem_ram.sv
// bus_mem_ram: single-port 2^AW x 32 synchronous RAM. The read data is
// registered, so a word appears one cycle after its address is presented.
// Contents are deliberately not reset.
module bus_mem_ram
   import bus_pkg::*;
#(
   parameter int unsigned AW = 10
) (
   input  logic          clk,
   input  logic          we_i,
   input  logic [AW-1:0] addr_i,
   input  logic [31:0]   wdata_i,
   output logic [31:0]   rdata_o
);

   localparam int unsigned DEPTH = 2 ** AW;

   logic [31:0] mem_q [DEPTH];
   logic [31:0] rdata_q;

   // Write port and registered read (read returns the old word on a write).
   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[addr_i] <= wdata_i;
      end
      rdata_q <= mem_q[addr_i];
   end

   assign rdata_o = rdata_q;

endmodule : bus_mem_ram

// File: rtl/bus_mem_resp.sv
// bus_mem_resp: bus target memory responder backing the video controller's
// fetch path. Accepts write bursts and burst reads against a word-addressed
// frame buffer and returns bid/grant-arbitrated responses.
// Optional feature macro: BUS_MEM_RESP_RANGECHK_EN (out-of-range requests
// answered with a single error beat instead of aliasing onto the RAM).
module bus_mem_resp
   import bus_pkg::*;
#(
   parameter int unsigned AW       = 10,
   parameter logic [3:0]  RESP_TAR = 4'h0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        selin,
   input  logic [2:0]  cmdin,
   input  logic [1:0]  lenin,
   input  logic [31:0] addrdatain,
   input  logic        ackin,
   output logic [1:0]  reqout,
   output logic [1:0]  lenout,
   output logic [31:0] addrdataout,
   output logic [2:0]  cmdout,
   output logic [3:0]  reqtar
);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_WR_DATA  = 3'd1,
      S_WR_BID   = 3'd2,
      S_WR_RESP  = 3'd3,
      S_RD_BID   = 3'd4,
      S_RD_DATA  = 3'd5,
      S_ERR_RESP = 3'd6
   } state_e;

   localparam logic [AW-1:0] IDX_ONE = {{(AW-1){1'b0}}, 1'b1};

   state_e        state_q, state_d;
   logic [AW-1:0] idx_q, idx_d;
   logic [3:0]    cnt_q, cnt_d;
   logic [1:0]    len_q, len_d;

   logic [AW-1:0] req_idx_s;
   logic [AW-1:0] ram_addr_s;
   logic          ram_we_s;
   logic [31:0]   ram_rdata_s;
   logic          err_s;
   logic [31:0]   err_addr_s;

   logic [1:0]    reqout_q, reqout_d;
   logic [1:0]    lenout_q, lenout_d;
   logic [31:0]   addrdataout_q, addrdataout_d;
   logic [2:0]    cmdout_q, cmdout_d;
   logic [3:0]    reqtar_q, reqtar_d;

   assign req_idx_s = addrdatain[AW+1:2];

`ifdef BUS_MEM_RESP_RANGECHK_EN
   logic        err_q, err_d;
   logic [31:0] addr_q, addr_d;

   // Capture the out-of-range flag and the raw request address.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         err_q  <= 1'b0;
         addr_q <= 32'd0;
      end else begin
         err_q  <= err_d;
         addr_q <= addr_d;
      end
   end

   // New request loads the flag and address; otherwise they hold.
   always_comb begin
      err_d  = err_q;
      addr_d = addr_q;
      if ((state_q == S_IDLE) && selin &&
          ((cmdin == WR_REQ) || (cmdin == RD_REQ))) begin
         err_d  = (addrdatain[31:AW+2] != '0);
         addr_d = addrdatain;
      end else begin
         err_d  = err_q;
         addr_d = addr_q;
      end
   end

   assign err_s      = err_q;
   assign err_addr_s = addr_q;
`else
   assign err_s      = 1'b0;
   assign err_addr_s = 32'd0;
`endif

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Word index, remaining-beat counter and captured length code.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         idx_q <= '0;
         cnt_q <= 4'd0;
         len_q <= 2'b00;
      end else begin
         idx_q <= idx_d;
         cnt_q <= cnt_d;
         len_q <= len_d;
      end
   end

   // Next state, datapath updates and RAM port control. During reads idx_q
   // tracks the word the RAM is currently presenting, so the address is
   // advanced one cycle before each beat is loaded into the output register.
   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      cnt_d      = cnt_q;
      len_d      = len_q;
      ram_addr_s = idx_q;
      ram_we_s   = 1'b0;
      case (state_q)
         S_IDLE: begin
            ram_addr_s = req_idx_s;
            if (selin && (cmdin == WR_REQ)) begin
               state_d = S_WR_DATA;
               idx_d   = req_idx_s;
               cnt_d   = len_to_beats(bus_len_e'(lenin));
               len_d   = lenin;
            end else if (selin && (cmdin == RD_REQ)) begin
               state_d = S_RD_BID;
               idx_d   = req_idx_s;
               cnt_d   = len_to_beats(bus_len_e'(lenin));
               len_d   = lenin;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_WR_DATA: begin
            if (cmdin == DATA) begin
               ram_we_s = !err_s;
               idx_d    = idx_q + IDX_ONE;
               cnt_d    = cnt_q - 4'd1;
               if (cnt_q == 4'd1) begin
                  state_d = S_WR_BID;
               end else begin
                  state_d = S_WR_DATA;
               end
            end else begin
               state_d = S_WR_DATA;
            end
         end
         S_WR_BID: begin
            if (ackin) begin
               state_d = err_s ? S_ERR_RESP : S_WR_RESP;
            end else begin
               state_d = S_WR_BID;
            end
         end
         S_WR_RESP: begin
            state_d = S_IDLE;
         end
         S_RD_BID: begin
            if (ackin && err_s) begin
               state_d = S_ERR_RESP;
            end else if (ackin) begin
               state_d    = S_RD_DATA;
               ram_addr_s = idx_q + IDX_ONE;
               idx_d      = idx_q + IDX_ONE;
            end else begin
               state_d = S_RD_BID;
            end
         end
         S_RD_DATA: begin
            ram_addr_s = idx_q + IDX_ONE;
            idx_d      = idx_q + IDX_ONE;
            cnt_d      = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
               state_d = S_IDLE;
            end else begin
               state_d = S_RD_DATA;
            end
         end
         S_ERR_RESP: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Output values for the coming cycle, decoded from the next state.
   always_comb begin
      reqout_d      = 2'b00;
      lenout_d      = 2'b00;
      addrdataout_d = 32'd0;
      cmdout_d      = IDLE;
      reqtar_d      = 4'h0;
      case (state_d)
         S_WR_BID, S_RD_BID: begin
            reqout_d = REQ_BID;
         end
         S_WR_RESP: begin
            reqout_d = REQ_BID;
            lenout_d = len_d;
            cmdout_d = WR_RESP;
            reqtar_d = RESP_TAR;
         end
         S_RD_DATA: begin
            reqout_d      = REQ_BID;
            lenout_d      = len_d;
            addrdataout_d = ram_rdata_s;
            cmdout_d      = RD_DATA;
            reqtar_d      = RESP_TAR;
         end
         S_ERR_RESP: begin
            reqout_d      = REQ_BID;
            lenout_d      = LEN_1;
            addrdataout_d = err_addr_s;
            cmdout_d      = ERR;
            reqtar_d      = RESP_TAR;
         end
         default: begin
            reqout_d = 2'b00;
         end
      endcase
   end

   // Output registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         reqout_q      <= 2'b00;
         lenout_q      <= 2'b00;
         addrdataout_q <= 32'd0;
         cmdout_q      <= 3'b000;
         reqtar_q      <= 4'h0;
      end else begin
         reqout_q      <= reqout_d;
         lenout_q      <= lenout_d;
         addrdataout_q <= addrdataout_d;
         cmdout_q      <= cmdout_d;
         reqtar_q      <= reqtar_d;
      end
   end

   assign reqout      = reqout_q;
   assign lenout      = lenout_q;
   assign addrdataout = addrdataout_q;
   assign cmdout      = cmdout_q;
   assign reqtar      = reqtar_q;

   bus_mem_ram #(
      .AW (AW)
   ) u_ram (
      .clk     (clk),
      .we_i    (ram_we_s),
      .addr_i  (ram_addr_s),
      .wdata_i (addrdatain),
      .rdata_o (ram_rdata_s)
   );

endmodule : bus_mem_resp
